// File: rtl/debug_unit_param_pkg.sv
// Shared command codes, reply bytes and state types
// for the UART debug controller.
package debug_unit_param_pkg;

  localparam logic [7:0] CMD_CONT  = 8'h63;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_NSTEP = 8'h6E;
  localparam logic [7:0] CMD_RST   = 8'h72;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  localparam int DEF_NUM_BYTES = 177;

  typedef enum logic [2:0] {
    IDLE,
    ARG,
    RUN,
    SETTLE,
    LOAD,
    XMIT
  } dbg_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT
  } tx_state_t;

  typedef enum logic {
    MODE_CONT,
    MODE_STEP
  } run_mode_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// Streams a header/reply byte followed by a
// snapshot buffer, one byte per UART done tick.
module debug_tx_serializer
  import debug_unit_param_pkg::*;
#(
  parameter int         NUM_BYTES = DEF_NUM_BYTES,
  parameter logic [7:0] FRAME_HDR = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic                         hdr_en,
  input  logic [7:0]                   reply,
  input  logic [$clog2(NUM_BYTES+1)-1:0] count,
  input  logic [8*NUM_BYTES-1:0]       data,
  input  logic                         tx_done_tick,
  output logic                         tx_start,
  output logic [7:0]                   tx_bus,
  output logic                         done
);

  localparam int CW = $clog2(NUM_BYTES + 1);

  tx_state_t             st_q;
  tx_state_t             st_d;
  logic [8*NUM_BYTES-1:0] buf_q;
  logic [CW-1:0]          cnt_q;
  logic [7:0]             bus_q;

  assign tx_bus = bus_q;

  // State register for the send/wait handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= TX_IDLE;
    else        st_q <= st_d;
  end

  // Next state, start strobe and end-of-frame flag.
  always_comb begin
    st_d     = st_q;
    tx_start = 1'b0;
    done     = 1'b0;
    unique case (st_q)
      TX_IDLE: if (load) st_d = TX_SEND;
      TX_SEND: begin
        tx_start = 1'b1;
        st_d     = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done_tick) begin
          if (cnt_q != '0) begin
            st_d = TX_SEND;
          end else begin
            st_d = TX_IDLE;
            done = 1'b1;
          end
        end
      end
      default: st_d = TX_IDLE;
    endcase
  end

  // Buffer capture on load, LSB-byte-first shift per byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      cnt_q <= '0;
      bus_q <= '0;
    end else if (load && st_q == TX_IDLE) begin
      buf_q <= data;
      cnt_q <= count;
      bus_q <= hdr_en ? FRAME_HDR : reply;
    end else if (st_q == TX_WAIT && tx_done_tick
                 && cnt_q != '0) begin
      bus_q <= buf_q[7:0];
      buf_q <= buf_q >> 8;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/debug_unit_param.sv
// UART debug controller: command decode, gated CPU
// run window, then a framed snapshot or ACK/NAK reply.
module debug_unit_param
  import debug_unit_param_pkg::*;
#(
  parameter int         NUM_BYTES   = DEF_NUM_BYTES,
  parameter int         RUN_TIMEOUT = 47,
  parameter logic [7:0] FRAME_HDR   = 8'hA5
) (
  input  logic                   top_clk,
  input  logic                   top_rst_n,
  input  logic                   rx_done_tick,
  input  logic [7:0]             rx_bus,
  input  logic                   tx_done_tick,
  input  logic [8*NUM_BYTES-1:0] send_data,
  input  logic                   halt,
  output logic                   enable,
  output logic                   cpu_reset,
  output logic                   tx_start,
  output logic [7:0]             tx_bus,
  output logic                   busy
);

  localparam int DEBUG = 8*NUM_BYTES - 1;
  localparam int CW    = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] FRAME_CNT = CW'(NUM_BYTES);
  localparam logic [15:0]   TO_LAST   = 16'(RUN_TIMEOUT - 1);

  dbg_state_t state_q;
  dbg_state_t state_d;
  run_mode_t  mode_q;
  logic [15:0] run_cnt;
  logic [7:0]  steps;
  logic        hdr_q;
  logic [7:0]  reply_q;
  logic        rst_q;
  logic        load;
  logic        ser_done;
  logic        run_last;
  logic        rx_idle;

  assign enable    = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign cpu_reset = rst_q;
  assign rx_idle   = rx_done_tick && state_q == IDLE;

  assign run_last = halt ||
    ((mode_q == MODE_CONT) ? (run_cnt == TO_LAST)
                           : (run_cnt == ({8'h00, steps} - 16'd1)));

  // Command FSM state register.
  always_ff @(posedge top_clk or negedge top_rst_n) begin
    if (!top_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Command FSM next state and serializer load strobe.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_done_tick) begin
          unique case (1'b1)
            rx_bus == CMD_CONT,
            rx_bus == CMD_STEP:  state_d = RUN;
            rx_bus == CMD_NSTEP: state_d = ARG;
            default:             state_d = LOAD;
          endcase
        end
      end
      ARG: begin
        if (rx_done_tick)
          state_d = (rx_bus == 8'h00) ? SETTLE : RUN;
      end
      RUN:    if (run_last) state_d = SETTLE;
      SETTLE: state_d = LOAD;
      LOAD: begin
        load    = 1'b1;
        state_d = XMIT;
      end
      XMIT:    if (ser_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Run counter, step count, reply selection, reset pulse.
  always_ff @(posedge top_clk or negedge top_rst_n) begin
    if (!top_rst_n) begin
      mode_q  <= MODE_CONT;
      run_cnt <= '0;
      steps   <= '0;
      hdr_q   <= 1'b0;
      reply_q <= '0;
      rst_q   <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      if (rx_idle) begin
        run_cnt <= '0;
        unique case (1'b1)
          rx_bus == CMD_CONT: begin
            mode_q <= MODE_CONT;
            hdr_q  <= 1'b1;
          end
          rx_bus == CMD_STEP: begin
            mode_q <= MODE_STEP;
            steps  <= 8'd1;
            hdr_q  <= 1'b1;
          end
          rx_bus == CMD_NSTEP: begin
            mode_q <= MODE_STEP;
            hdr_q  <= 1'b1;
          end
          rx_bus == CMD_RST: begin
            hdr_q   <= 1'b0;
            reply_q <= ACK_BYTE;
            rst_q   <= 1'b1;
          end
          default: begin
            hdr_q   <= 1'b0;
            reply_q <= NAK_BYTE;
          end
        endcase
      end else if (state_q == ARG && rx_done_tick) begin
        steps   <= rx_bus;
        run_cnt <= '0;
      end else if (state_q == RUN) begin
        run_cnt <= run_cnt + 16'd1;
      end
    end
  end

  debug_tx_serializer #(
    .NUM_BYTES (NUM_BYTES),
    .FRAME_HDR (FRAME_HDR)
  ) u_ser (
    .clk          (top_clk),
    .rst_n        (top_rst_n),
    .load         (load),
    .hdr_en       (hdr_q),
    .reply        (reply_q),
    .count        (hdr_q ? FRAME_CNT : '0),
    .data         (send_data[DEBUG:0]),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_bus       (tx_bus),
    .done         (ser_done)
  );

endmodule

// File: tb/tb_debug_unit_param.sv
// Scoreboard bench for debug_unit_param with a UART
// responder and a command-level reference model.
module tb_debug_unit_param;

  localparam int NB = 177;
  localparam int TO = 47;

  logic          top_clk = 1'b0;
  logic          top_rst_n = 1'b0;
  logic          rx_done_tick = 1'b0;
  logic [7:0]    rx_bus = 8'h00;
  logic          tx_done_tick = 1'b0;
  logic [8*NB-1:0] send_data = '0;
  logic          halt = 1'b0;
  logic          enable;
  logic          cpu_reset;
  logic          tx_start;
  logic [7:0]    tx_bus;
  logic          busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] snap[NB];
  int en_total = 0;
  int rst_total = 0;
  int tx_total = 0;
  int en_base = 0;
  int halt_at = 0;
  bit in_rst = 1'b0;

  debug_unit_param #(
    .NUM_BYTES   (NB),
    .RUN_TIMEOUT (TO),
    .FRAME_HDR   (8'hA5)
  ) dut (
    .top_clk      (top_clk),
    .top_rst_n    (top_rst_n),
    .rx_done_tick (rx_done_tick),
    .rx_bus       (rx_bus),
    .tx_done_tick (tx_done_tick),
    .send_data    (send_data),
    .halt         (halt),
    .enable       (enable),
    .cpu_reset    (cpu_reset),
    .tx_start     (tx_start),
    .tx_bus       (tx_bus),
    .busy         (busy)
  );

  always #5 top_clk = ~top_clk;

  task automatic chk(input string nm, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // Scoreboard monitor: every tx_start pops one byte.
  initial begin : monitor
    logic prev;
    logic [7:0] e;
    prev = 1'b0;
    forever begin
      @(negedge top_clk);
      if (tx_start) begin
        tx_total++;
        chk("tx_b2b", int'(prev), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %02h want none",
                   tx_bus);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", int'(tx_bus), int'(e));
        end
      end
      prev = tx_start;
    end
  end

  // Counts enable/cpu_reset cycles, raises halt on cue.
  initial begin : observer
    forever begin
      @(negedge top_clk);
      if (enable) en_total++;
      if (cpu_reset) rst_total++;
      if (halt_at > 0 && enable && en_total - en_base >= halt_at)
        halt = 1'b1;
    end
  end

  // UART responder: random latency done tick per byte.
  initial begin : uart
    logic [7:0] b;
    forever begin
      @(negedge top_clk);
      while (tx_start) begin
        b = tx_bus;
        repeat ($urandom_range(3, 1)) @(negedge top_clk);
        if (!in_rst) chk("tx_hold", int'(tx_bus), int'(b));
        tx_done_tick = 1'b1;
        @(negedge top_clk);
        tx_done_tick = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge top_clk);
    rx_bus = b;
    rx_done_tick = 1'b1;
    @(negedge top_clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic set_data(input bit pat);
    for (int i = 0; i < NB; i++) begin
      snap[i] = pat ? 8'(i) : 8'($urandom);
      send_data[8*i +: 8] = snap[i];
    end
  endtask

  task automatic push_frame();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NB; i++) exp_q.push_back(snap[i]);
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 20000; i++) begin
      if (!busy) break;
      @(negedge top_clk);
    end
    chk({nm, "_done"}, int'(busy), 0);
  endtask

  task automatic wait_tx(input int tgt, input string nm);
    for (int i = 0; i < 5000 && tx_total < tgt; i++)
      @(negedge top_clk);
    chk({nm, "_txcnt"}, int'(tx_total >= tgt), 1);
  endtask

  // hm: 0 no halt, -1 halt high before start, n>0 halt on nth enable
  task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] k,
                         input int hm, input string nm);
    int exp_en, exp_rst, lim, h, rbase;
    exp_en = 0;
    exp_rst = 0;
    lim = -1;
    h = (hm < 0) ? 1 : hm;
    if (cmd == 8'h63) lim = TO;
    else if (cmd == 8'h73) lim = 1;
    else if (cmd == 8'h6E) lim = int'(k);
    if (lim >= 0) begin
      exp_en = (lim > 0 && h > 0 && h < lim) ? h : lim;
      push_frame();
    end else if (cmd == 8'h72) begin
      exp_rst = 1;
      exp_q.push_back(8'h06);
    end else begin
      exp_q.push_back(8'h15);
    end
    en_base = en_total;
    rbase = rst_total;
    halt_at = (hm > 0) ? hm : 0;
    halt = (hm < 0);
    send_byte(cmd);
    if (cmd == 8'h6E) send_byte(k);
    wait_idle(nm);
    chk({nm, "_enable"}, en_total - en_base, exp_en);
    chk({nm, "_cpu_reset"}, rst_total - rbase, exp_rst);
    chk({nm, "_left"}, exp_q.size(), 0);
    halt = 1'b0;
    halt_at = 0;
  endtask

  initial begin : stim
    int base, r, hm;
    logic [7:0] c, k;
    repeat (3) @(negedge top_clk);
    chk("rst_enable", int'(enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_bus", int'(tx_bus), 0);
    chk("rst_cpu_reset", int'(cpu_reset), 0);
    top_rst_n = 1'b1;
    repeat (2) @(negedge top_clk);

    set_data(1'b1);
    run_cmd(8'h73, 8'h00, 0, "step_pat");
    set_data(1'b0);
    run_cmd(8'h63, 8'h00, 0, "cont_to");
    run_cmd(8'h63, 8'h00, 10, "cont_halt10");
    run_cmd(8'h63, 8'h00, -1, "cont_halt_pre");
    run_cmd(8'h6E, 8'd5, 0, "nstep5");
    run_cmd(8'h6E, 8'd0, 0, "nstep0");
    run_cmd(8'h6E, 8'd200, 0, "nstep200");
    run_cmd(8'h72, 8'h00, 0, "cpu_rst");
    run_cmd(8'h78, 8'h00, 0, "nak_x");

    // commands arriving mid-frame are ignored
    set_data(1'b0);
    push_frame();
    en_base = en_total;
    base = tx_total;
    send_byte(8'h73);
    wait_tx(base + 5, "busy_cmd");
    send_byte(8'h63);
    chk("busy_hold1", int'(busy), 1);
    send_byte(8'h73);
    chk("busy_hold2", int'(busy), 1);
    wait_idle("busy_cmd");
    chk("busy_cmd_enable", en_total - en_base, 1);
    chk("busy_cmd_left", exp_q.size(), 0);

    // reset mid-frame aborts the frame
    push_frame();
    base = tx_total;
    send_byte(8'h73);
    wait_tx(base + 10, "midrst");
    #1;
    in_rst = 1'b1;
    top_rst_n = 1'b0;
    exp_q.delete();
    @(negedge top_clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_tx_bus", int'(tx_bus), 0);
    chk("midrst_enable", int'(enable), 0);
    repeat (2) @(negedge top_clk);
    top_rst_n = 1'b1;
    base = tx_total;
    repeat (60) @(negedge top_clk);
    chk("midrst_no_tx", tx_total - base, 0);
    chk("midrst_idle", int'(busy), 0);
    in_rst = 1'b0;
    run_cmd(8'h73, 8'h00, 0, "post_rst_step");

    // randomized command mix
    for (int i = 0; i < 10; i++) begin
      set_data(1'b0);
      r = $urandom_range(4, 0);
      k = 8'($urandom_range(12, 0));
      hm = int'($urandom_range(3, 0)) - 1;
      if (hm > 0) hm = $urandom_range(20, 1);
      unique case (r)
        0: c = 8'h63;
        1: c = 8'h73;
        2: c = 8'h6E;
        3: c = 8'h72;
        default: begin
          c = 8'($urandom);
          while (c == 8'h63 || c == 8'h73 ||
                 c == 8'h6E || c == 8'h72)
            c = 8'($urandom);
        end
      endcase
      run_cmd(c, k, hm, "rand");
    end

    repeat (5) @(negedge top_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_unit_param.md
Name: debug_unit_param

Overview:
- Parametrised UART debug controller for the MIPS/DLX core: decodes single-byte host commands from the UART RX, gates the CPU `enable` for a controlled number of cycles, then snapshots the `send_data` debug bus and streams it back byte by byte through the UART TX.
- Successor to the fixed-size step/continue debug unit. Adds:
  - parametrised snapshot width and run timeout;
  - an N-step command with an argument byte;
  - halt-driven early stop;
  - a CPU reset command;
  - framed replies with header and ACK/NAK bytes.

Parameters:
- NUM_BYTES, 177, snapshot length in bytes. The data bus is 8*NUM_BYTES bits wide.
- RUN_TIMEOUT, 47, maximum enable cycles for 'c' when `halt` never asserts. Legal range 1..65535.
- FRAME_HDR, 8'hA5, header byte sent before every snapshot.

Ports:
- top_clk  in  1  system clock
- top_rst_n  in  1  asynchronous active-low reset
- rx_done_tick  in  1  one-cycle strobe: rx_bus holds a valid received byte
- rx_bus  in  8  received byte
- tx_done_tick  in  1  one-cycle strobe: UART finished the current byte
- send_data  in  8*NUM_BYTES  debug snapshot bus, byte 0 = bits [7:0]
- halt  in  1  CPU reached end of program
- enable  out  1  CPU clock-enable
- cpu_reset  out  1  one-cycle CPU reset pulse
- tx_start  out  1  one-cycle strobe: start sending tx_bus
- tx_bus  out  8  byte to transmit
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, top_rst_n=0):
  - state=IDLE;
  - enable, cpu_reset, tx_start, busy = 0;
  - tx_bus=0, shift buffer=0, counters=0.
  - Reset asserted mid-run or mid-send aborts immediately. No partial frame is completed after release.
- States: IDLE, ARG, RUN, SETTLE, LOAD, SEND, WAIT_TX.
- Command decode happens only in IDLE on rx_done_tick. rx_done_tick in any state other than IDLE/ARG is ignored.
  - 'c' (8'h63): run_cnt=0, go to RUN, mode=CONT.
  - 's' (8'h73): steps=1, go to RUN, mode=STEP.
  - 'n' (8'h6E): go to ARG. The next rx byte K loads steps=K, then go to RUN. K=0 skips RUN and goes directly to SETTLE, so the host gets a snapshot with no execution.
  - 'r' (8'h72): cpu_reset=1 for exactly one cycle, then a reply of the single byte ACK 8'h06 (no snapshot).
  - Any other byte: reply with the single byte NAK 8'h15.
- RUN:
  - enable=1 in every RUN cycle; run_cnt increments each cycle.
  - Exit condition, evaluated on registered values each cycle:
    - CONT: exits when halt=1 or run_cnt==RUN_TIMEOUT-1;
    - STEP/'n': exits when run_cnt==steps-1, or early when halt=1.
  - The exit cycle itself has enable=1, so 's' gives exactly one enable cycle and 'n' K gives exactly K (absent halt).
  - halt already high on entry: exactly one enable cycle.
- SETTLE: enable=0 for one cycle so the pipeline outputs settle.
- LOAD: buffer<=send_data, byte_cnt<=NUM_BYTES, tx_bus<=FRAME_HDR.
- SEND: tx_start=1 for one cycle, then WAIT_TX.
- WAIT_TX: tx_bus is held stable until tx_done_tick. On tx_done_tick:
  - if byte_cnt>0: tx_bus<=buffer[7:0], buffer>>=8, byte_cnt-=1, go to SEND;
  - else go to IDLE.
- Frame on the wire: FRAME_HDR, then bytes 0..NUM_BYTES-1 (LSB byte first), NUM_BYTES+1 bytes total.
- ACK/NAK replies reuse SEND/WAIT_TX with byte_cnt=0.
- tx_start is never high in two consecutive cycles. A tx_done_tick outside WAIT_TX is ignored.
- Counter widths: run_cnt 16 bits; byte_cnt $clog2(NUM_BYTES+1) bits; steps 8 bits.

Decomposition:
- Shared header definiciones.vh holds:
  - command codes CMD_CONT, CMD_STEP, CMD_NSTEP, CMD_RST;
  - ACK_BYTE, NAK_BYTE;
  - default NUM_BYTES and debug bus width constants (DEBUG = 8*NUM_BYTES-1).
- One sub-module, debug_tx_serializer:
  - owns the buffer, byte_cnt and SEND/WAIT_TX;
  - takes a load strobe, a header-enable flag and a byte count.
- The parent keeps the command FSM, RUN counter and enable/cpu_reset generation.

Test Plan:
- Reset mid-frame: reset after 10 bytes -> tx_start stays 0 after release. A new 's' produces a full 178-byte frame.
- 's' with send_data pattern byte i = i mod 256 -> enable high exactly 1 cycle. TX sequence is A5,00,01,...,B0 (178 bytes), one tx_start per tx_done_tick.
- 'c' with halt never asserted -> enable high exactly 47 consecutive cycles, then the frame. 'c' with halt raised on the 10th enable cycle -> exactly 10 enable cycles.
- 'n' then K=5 -> 5 enable cycles. 'n' then K=0 -> 0 enable cycles, frame still sent.
- 'r' -> cpu_reset high for 1 cycle, single TX byte 06, enable stays 0. Byte 'x' -> single TX byte 15.
- Commands sent while busy (e.g. 's' during WAIT_TX) are ignored: the frame completes unchanged, busy=1 throughout, and no extra enable pulse occurs.
